// File: rtl/window_collector.sv
// ----------------------------------------------------------------------------
// window_collector
// Streaming KxK sliding-window generator. Pixels arrive one per cycle in
// raster order; K-1 previous rows are held in line buffers and a full KxK
// window is presented on a registered output that honours backpressure.
//
// Handshake semantics (both channels): a transfer happens on a rising edge
// where valid && ready are both high. A producer holding valid keeps its
// payload stable until the transfer; ready never depends on valid.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   stage_width     row length of the frame   (latched on pixel (0,0))
//   stage_height    row count of the frame    (latched on pixel (0,0))
//   stride2         0 = stride 1, 1 = stride 2 (latched on pixel (0,0))
//   pixel_in        input pixel, qualified by in_valid / in_ready
//   win_out         KxK window, element r*K+c, r=0 top row, c=0 left column
//   win_valid       win_out holds an unconsumed window; win_ready consumes
//   win_last        window whose bottom-right is the frame's last pixel
//   frame_done      one-cycle pulse after the frame's last pixel is accepted
//   cfg_err         current frame dimensions are illegal
// ----------------------------------------------------------------------------
module window_collector #(
   parameter int DATA_W     = 8,
   parameter int K          = 3,
   parameter int MAX_WIDTH  = 128,
   parameter int MAX_HEIGHT = 128,
   parameter int DIM_W      = $clog2(MAX_WIDTH > MAX_HEIGHT ? MAX_WIDTH : MAX_HEIGHT) + 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [DIM_W-1:0]        stage_width,
   input  logic [DIM_W-1:0]        stage_height,
   input  logic                    stride2,
   input  logic [DATA_W-1:0]       pixel_in,
   input  logic                    in_valid,
   output logic                    in_ready,
   output logic [K*K*DATA_W-1:0]   win_out,
   output logic                    win_valid,
   input  logic                    win_ready,
   output logic                    win_last,
   output logic                    frame_done,
   output logic                    cfg_err
);

   localparam int AW    = (MAX_WIDTH > 1) ? $clog2(MAX_WIDTH) : 1;
   localparam int COL_W = K * DATA_W;

   localparam logic [DIM_W-1:0] C_ONE  = DIM_W'(1);
   localparam logic [DIM_W-1:0] C_K    = DIM_W'(K);
   localparam logic [DIM_W-1:0] C_KM1  = DIM_W'(K - 1);
   localparam logic [DIM_W-1:0] C_MAXW = DIM_W'(MAX_WIDTH);
   localparam logic [DIM_W-1:0] C_MAXH = DIM_W'(MAX_HEIGHT);

   // position and latched frame configuration
   logic [DIM_W-1:0]   r_col;
   logic [DIM_W-1:0]   r_row;
   logic [DIM_W-1:0]   r_width;
   logic [DIM_W-1:0]   r_height;
   logic               r_stride2;

   // line buffers: r_lb[0] is the oldest row, r_lb[K-2] the previous row
   logic [DATA_W-1:0]  r_lb [K-1][MAX_WIDTH];
   // the K-1 columns to the left of the current pixel, oldest at index 0
   logic [COL_W-1:0]   r_sh [K-1];

   // output registers
   logic [K*K*DATA_W-1:0] r_win;
   logic                  r_win_valid;
   logic                  r_win_last;
   logic                  r_frame_done;
   logic                  r_cfg_err;

   logic                  w_accept;
   logic                  w_origin;
   logic [DIM_W-1:0]      w_width;
   logic [DIM_W-1:0]      w_height;
   logic                  w_stride2;
   logic [DIM_W-1:0]      w_width_eff;
   logic [DIM_W-1:0]      w_height_eff;
   logic                  w_err;
   logic                  w_col_end;
   logic                  w_row_end;
   logic                  w_emit;
   logic [AW-1:0]         w_idx;
   logic [COL_W-1:0]      w_col_new;
   logic [K*K*DATA_W-1:0] w_win_new;

   assign in_ready = !rst && (!r_win_valid || win_ready);
   assign w_accept = in_valid && in_ready;
   assign w_origin = (r_col == '0) && (r_row == '0);

   // Pixel (0,0) is judged with the live port values, since that is the
   // accept on which they are latched; every later pixel uses the latch.
   assign w_width   = w_origin ? stage_width  : r_width;
   assign w_height  = w_origin ? stage_height : r_height;
   assign w_stride2 = w_origin ? stride2      : r_stride2;

   // A zero dimension still counts as one pixel so the frame terminates.
   assign w_width_eff  = (w_width  == '0) ? C_ONE : w_width;
   assign w_height_eff = (w_height == '0) ? C_ONE : w_height;

   assign w_err = (w_width  < C_K) || (w_width  > C_MAXW) ||
                  (w_height < C_K) || (w_height > C_MAXH);

   assign w_col_end = (r_col == w_width_eff  - C_ONE);
   assign w_row_end = (r_row == w_height_eff - C_ONE);

   // K-1 is even for odd K, so the stride-2 phase test reduces to matching
   // the low bit of the position with the low bit of K-1.
   assign w_emit = !w_err && (r_row >= C_KM1) && (r_col >= C_KM1) &&
                   (!w_stride2 || ((r_row[0] == C_KM1[0]) && (r_col[0] == C_KM1[0])));

   // Only legal frames touch the line buffers, so the width bound
   // guarantees the index stays inside the buffer depth.
   assign w_idx = r_col[AW-1:0];

   always_comb begin
      w_col_new = '0;
      for (int r = 0; r < K - 1; r++) begin
         w_col_new[r*DATA_W +: DATA_W] = r_lb[r][w_idx];
      end
      w_col_new[(K-1)*DATA_W +: DATA_W] = pixel_in;
   end

   always_comb begin
      w_win_new = '0;
      for (int r = 0; r < K; r++) begin
         for (int c = 0; c < K - 1; c++) begin
            w_win_new[(r*K + c)*DATA_W +: DATA_W] = r_sh[c][r*DATA_W +: DATA_W];
         end
         w_win_new[(r*K + K - 1)*DATA_W +: DATA_W] = w_col_new[r*DATA_W +: DATA_W];
      end
   end

   // Position counters and configuration latch.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_col     <= '0;
         r_row     <= '0;
         r_width   <= '0;
         r_height  <= '0;
         r_stride2 <= 1'b0;
         r_cfg_err <= 1'b0;
      end else if (w_accept) begin
         if (w_origin) begin
            r_width   <= stage_width;
            r_height  <= stage_height;
            r_stride2 <= stride2;
            r_cfg_err <= w_err;
         end
         if (w_col_end && w_row_end) begin
            r_col <= '0;
            r_row <= '0;
         end else if (w_col_end) begin
            r_col <= '0;
            r_row <= r_row + C_ONE;
         end else begin
            r_col <= r_col + C_ONE;
         end
      end
   end

   // Line-buffer column shift and left-column history; contents are not
   // reset because the emission condition masks anything stale.
   always_ff @(posedge clk) begin
      if (w_accept && !w_err) begin
         for (int i = 0; i < K - 2; i++) begin
            r_lb[i][w_idx] <= r_lb[i+1][w_idx];
         end
         r_lb[K-2][w_idx] <= pixel_in;
         for (int j = 0; j < K - 2; j++) begin
            r_sh[j] <= r_sh[j+1];
         end
         r_sh[K-2] <= w_col_new;
      end
   end

   // Output window register. An accept is only possible when the slot is
   // empty or being consumed, so it may overwrite or drop the slot freely.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_win        <= '0;
         r_win_valid  <= 1'b0;
         r_win_last   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_accept && w_col_end && w_row_end;
         if (w_accept) begin
            if (w_emit) begin
               r_win       <= w_win_new;
               r_win_valid <= 1'b1;
               r_win_last  <= w_col_end && w_row_end;
            end else begin
               r_win_valid <= 1'b0;
               r_win_last  <= 1'b0;
            end
         end else if (win_ready) begin
            r_win_valid <= 1'b0;
            r_win_last  <= 1'b0;
         end
      end
   end

   assign win_out    = r_win;
   assign win_valid  = r_win_valid;
   assign win_last   = r_win_last;
   assign frame_done = r_frame_done;
   assign cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_window_collector.sv
// ----------------------------------------------------------------------------
// tb_window_collector
// Drives a K=3 and a K=5 instance (one active at a time through a select)
// with whole frames described by a table, compares every consumed window
// against a pixel-formula model, and adds hand-written sequences for
// backpressure and reset in the middle of a frame.
// ----------------------------------------------------------------------------
module tb_window_collector;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic [7:0]  stage_width;
   logic [7:0]  stage_height;
   logic        stride2;
   logic [7:0]  pix;
   logic        vld;
   logic        wr;
   logic        sel;

   logic        u3_in_ready, u3_wv, u3_wl, u3_fd, u3_err;
   logic [71:0] u3_win;
   logic        u5_in_ready, u5_wv, u5_wl, u5_fd, u5_err;
   logic [199:0] u5_win;

   logic        m_in_ready, m_wv, m_wl, m_fd, m_err;
   logic [199:0] m_win;

   window_collector #(.DATA_W(8), .K(3), .MAX_WIDTH(128), .MAX_HEIGHT(128)) u3 (
      .clk(clk), .rst(rst), .stage_width(stage_width), .stage_height(stage_height),
      .stride2(stride2), .pixel_in(pix), .in_valid(vld && !sel), .in_ready(u3_in_ready),
      .win_out(u3_win), .win_valid(u3_wv), .win_ready(wr), .win_last(u3_wl),
      .frame_done(u3_fd), .cfg_err(u3_err));

   window_collector #(.DATA_W(8), .K(5), .MAX_WIDTH(128), .MAX_HEIGHT(128)) u5 (
      .clk(clk), .rst(rst), .stage_width(stage_width), .stage_height(stage_height),
      .stride2(stride2), .pixel_in(pix), .in_valid(vld && sel), .in_ready(u5_in_ready),
      .win_out(u5_win), .win_valid(u5_wv), .win_ready(wr), .win_last(u5_wl),
      .frame_done(u5_fd), .cfg_err(u5_err));

   assign m_in_ready = sel ? u5_in_ready : u3_in_ready;
   assign m_wv       = sel ? u5_wv       : u3_wv;
   assign m_wl       = sel ? u5_wl       : u3_wl;
   assign m_fd       = sel ? u5_fd       : u3_fd;
   assign m_err      = sel ? u5_err      : u3_err;
   assign m_win      = sel ? u5_win      : {128'b0, u3_win};

   int total = 0;
   int bad   = 0;
   int got_cnt  = 0;
   int first_at = -1;
   int acc_cnt  = 0;
   logic [200:0] exp_q[$];

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] pix_f(input int mode, input int r, input int c);
      case (mode)
         0:       return 8'(c);
         1:       return 8'(r * 16 + c);
         default: return 8'(255 - (r * 16 + c));
      endcase
   endfunction

   function automatic logic [199:0] model_win(input int k, input int mode, input int r, input int c);
      logic [199:0] w;
      w = '0;
      for (int i = 0; i < k; i++)
         for (int j = 0; j < k; j++)
            w[(i*k + j)*8 +: 8] = pix_f(mode, r - k + 1 + i, c - k + 1 + j);
      return w;
   endfunction

   // scoreboard: every consumed window is checked against the next expectation
   always @(negedge clk) begin
      logic [200:0] e;
      if (m_wv && wr) begin
         if (got_cnt == 0) first_at = acc_cnt;
         got_cnt++;
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL window_unexpected: got %h expected none", m_win);
         end else begin
            e = exp_q.pop_front();
            chk("window", {m_wl, m_win}, e);
         end
      end
   end

   // Streams npix pixels (-1 = whole frame); optionally stalls the consumer
   // for 5 cycles once 5 windows have been taken.
   task automatic run_frame(input int k, input int w, input int h, input int s2,
                            input int mode, input int npix, input int bp);
      int we, he, legal, n;
      sel          = (k == 5);
      stage_width  = 8'(w);
      stage_height = 8'(h);
      stride2      = s2[0];
      we    = (w == 0) ? 1 : w;
      he    = (h == 0) ? 1 : h;
      legal = (w >= k && w <= 128 && h >= k && h <= 128) ? 1 : 0;
      n     = we * he;
      if (npix >= 0 && npix < n) n = npix;
      for (int idx = 0; idx < n; idx++) begin
         int r, c;
         r = idx / we;
         c = idx % we;
         if (legal != 0 && r >= k - 1 && c >= k - 1 &&
             (s2 == 0 || (((r - k + 1) % 2) == 0 && ((c - k + 1) % 2) == 0)))
            exp_q.push_back({(r == he - 1 && c == we - 1) ? 1'b1 : 1'b0,
                             model_win(k, mode, r, c)});
      end
      got_cnt  = 0;
      first_at = -1;
      acc_cnt  = 0;
      fork
         begin
            for (int idx = 0; idx < n; idx++) begin
               int ok;
               pix = pix_f(mode, idx / we, idx % we);
               vld = 1'b1;
               ok  = 0;
               for (int t = 0; t < 300 && ok == 0; t++) begin
                  @(negedge clk);
                  if (m_in_ready) ok = 1;
               end
               if (ok == 0) begin
                  total++;
                  bad++;
                  $display("FAIL in_ready_timeout: got 0 expected 1 at pixel %0d", idx);
                  break;
               end
               @(posedge clk);
               #1;
               acc_cnt++;
               if (acc_cnt == 1) chk("cfg_err_start", m_err, (legal != 0) ? 0 : 1);
            end
            vld = 1'b0;
         end
         begin
            if (bp != 0) begin
               logic [199:0] held;
               int t;
               t = 0;
               while (got_cnt < 5 && t < 2000) begin
                  @(posedge clk);
                  t++;
               end
               chk("bp_reached", (got_cnt >= 5) ? 1 : 0, 1);
               #1;
               wr = 1'b0;
               @(negedge clk);
               held = m_win;
               for (int i = 0; i < 5; i++) begin
                  if (i != 0) @(negedge clk);
                  chk("bp_valid_held", m_wv, 1);
                  chk("bp_win_stable", m_win, held);
                  chk("bp_in_ready_low", m_in_ready, 0);
               end
               @(posedge clk);
               #1;
               wr = 1'b1;
            end
         end
      join
   endtask

   // Called right after the final accept; finishes by draining the output.
   task automatic end_checks(input int exp_n, input int exp_last, input int exp_err, input int exp_first);
      chk("frame_done", m_fd, 1);
      chk("last_with_done", m_wv && m_wl, exp_last);
      chk("cfg_err_end", m_err, exp_err);
      @(posedge clk);
      #1;
      chk("frame_done_pulse", m_fd, 0);
      for (int t = 0; t < 50 && exp_q.size() != 0; t++) @(posedge clk);
      #1;
      chk("win_count", got_cnt, exp_n);
      chk("first_window_at", first_at, exp_first);
      chk("queue_empty", exp_q.size(), 0);
   endtask

   typedef struct {
      int k; int w; int h; int s2; int mode; int bp;
      int exp_n; int exp_last; int exp_err; int exp_first;
   } vec_t;

   vec_t vecs[13];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //          k  w    h  s2 md bp  n  last err first
      vecs[0]  = '{3,   8, 8, 0, 0, 0, 36, 1, 0, 19};
      vecs[1]  = '{3,   8, 8, 1, 0, 0,  9, 0, 0, 19};
      vecs[2]  = '{3,   8, 8, 0, 1, 1, 36, 1, 0, 19};
      vecs[3]  = '{3,   2, 4, 0, 1, 0,  0, 0, 1, -1};
      vecs[4]  = '{3,   8, 8, 0, 1, 0, 36, 1, 0, 19};
      vecs[5]  = '{3,   3, 3, 0, 1, 0,  1, 1, 0,  9};
      vecs[6]  = '{3,   7, 5, 1, 1, 0,  6, 1, 0, 17};
      vecs[7]  = '{3,   0, 5, 0, 1, 0,  0, 0, 1, -1};
      vecs[8]  = '{3, 129, 3, 0, 1, 0,  0, 0, 1, -1};
      vecs[9]  = '{3, 128, 3, 1, 1, 0, 63, 0, 0, 259};
      vecs[10] = '{5,   6, 6, 0, 1, 0,  4, 1, 0, 29};
      vecs[11] = '{5,   8, 8, 0, 1, 0, 16, 1, 0, 37};
      vecs[12] = '{5,   4, 8, 0, 1, 0,  0, 0, 1, -1};

      rst = 1'b1; vld = 1'b0; wr = 1'b1; sel = 1'b0; pix = '0;
      stage_width = 8'd8; stage_height = 8'd8; stride2 = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", m_in_ready, 0);
      chk("rst_win_valid", m_wv, 0);
      chk("rst_win_last", m_wl, 0);
      chk("rst_win_out", m_win, 0);
      chk("rst_frame_done", m_fd, 0);
      chk("rst_cfg_err", m_err, 0);
      chk("rst_win_out_k5", u5_win, 0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("in_ready_after_rst", m_in_ready, 1);

      for (int i = 0; i < 13; i++) begin
         run_frame(vecs[i].k, vecs[i].w, vecs[i].h, vecs[i].s2, vecs[i].mode, -1, vecs[i].bp);
         end_checks(vecs[i].exp_n, vecs[i].exp_last, vecs[i].exp_err, vecs[i].exp_first);
      end

      // reset after 30 accepts of an 8x8 frame, with the 10th window held
      run_frame(3, 8, 8, 0, 1, 30, 0);
      wr  = 1'b0;
      rst = 1'b1;
      #1;
      chk("midrst_windows_taken", got_cnt, 9);
      chk("midrst_pending", exp_q.size(), 1);
      chk("midrst_valid_before", m_wv, 1);
      chk("midrst_in_ready", m_in_ready, 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      chk("midrst_win_valid", m_wv, 0);
      chk("midrst_win_last", m_wl, 0);
      void'(exp_q.pop_back());
      wr = 1'b1;
      @(posedge clk);
      #1;
      run_frame(3, 8, 8, 0, 2, -1, 0);
      end_checks(36, 1, 0, 19);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
